// File: rtl/mdp3_pkg.sv
// Shared types, sizes and byte-order helpers for the MDP3 packet/message splitter.
package mdp3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PKT_HDR,
        MSG_SIZE,
        MSG_BODY,
        DROP
    } state_e;

    localparam int PKT_HDR_BYTES  = 12;
    localparam int MSG_SIZE_BYTES = 2;
    localparam int SBE_HDR_BYTES  = 8;

    // Wire order is first byte in the MSBs; MDP3 fields are little-endian.
    function automatic logic [15:0] le16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [31:0] le32(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[31-8*b -: 8];
        return r;
    endfunction

    function automatic logic [63:0] le64(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = w[63-8*b -: 8];
        return r;
    endfunction

    // Zero every byte of a left-justified word beyond the first n.
    function automatic logic [63:0] keep_bytes(input logic [63:0] w, input logic [3:0] n);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n) m[63-8*b -: 8] = w[63-8*b -: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_shift_buf.sv
// 16-byte left-justified byte buffer: pop up to 8 bytes from the head and
// append up to 8 bytes behind the survivors in the same cycle.
module byte_shift_buf
    import mdp3_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic [3:0]  push_n,
    input  logic [3:0]  pop_n,
    output logic [63:0] head,
    output logic [4:0]  fill
);

    logic [127:0] buf_q, buf_d;
    logic [4:0]   fill_q, fill_d;
    logic [4:0]   keep;
    logic [127:0] shifted;
    logic [127:0] ins;

    assign head = buf_q[127:64];
    assign fill = fill_q;

    // Shift out the popped head bytes, then land the pushed bytes right behind what is left.
    always_comb begin
        keep    = fill_q - {1'b0, pop_n};
        shifted = buf_q << {pop_n, 3'b000};
        ins     = {keep_bytes(push_data, push_n), 64'd0} >> {keep, 3'b000};
        buf_d   = '0;
        for (int i = 0; i < 16; i++) begin
            buf_d[127-8*i -: 8] = (5'(i) < keep) ? shifted[127-8*i -: 8] : ins[127-8*i -: 8];
        end
        fill_d = keep + (push ? {1'b0, push_n} : 5'd0);
        if (clear) fill_d = 5'd0;
    end

    // Fill count is the only control state; byte contents beyond fill are don't-care.
    always_ff @(posedge clk) begin
        if (!reset_n) fill_q <= 5'd0;
        else          fill_q <= fill_d;
    end

    // Byte storage.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/mdp3_msg_splitter.sv
// Parses the MDP3 packet header from a UDP payload stream and splits the
// remainder into re-aligned SBE messages with sideband and status counters.
module mdp3_msg_splitter
    import mdp3_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MIN_MSG_SIZE = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [3:0]       in_bytes,
    output logic             in_ready,
    output logic [63:0]      out_data,
    output logic [3:0]       out_bytes,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [31:0]      msg_seq_num,
    output logic [63:0]      sending_time,
    output logic [15:0]      msg_size,
    output logic [15:0]      msg_template_id,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic             eod_q, eod_d;           // in_last already accepted for this datagram
    logic             hdr_half_q, hdr_half_d; // first 8 header bytes taken
    logic [63:0]      hdr_lo_q, hdr_lo_d;
    logic [15:0]      body_rem_q, body_rem_d;
    logic             sop_pend_q, sop_pend_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic             out_err_q, out_err_d;
    logic [63:0]      out_data_q, out_data_d;
    logic [3:0]       out_bytes_q, out_bytes_d;
    logic [31:0]      msg_seq_num_q, msg_seq_num_d;
    logic [63:0]      sending_time_q, sending_time_d;
    logic [15:0]      msg_size_q, msg_size_d;
    logic [15:0]      msg_template_id_q, msg_template_id_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] msg_count_q, msg_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        in_fire;
    logic [63:0] head;
    logic [4:0]  fill;
    logic [3:0]  pop_n;
    logic        buf_clear;
    logic [4:0]  need;
    logic [15:0] sz;
    logic        to_idle;
    logic        err_inc;

    // DROP swallows words regardless of fill; otherwise stop accepting once the
    // datagram's last word is in, so the next datagram never mixes into this one.
    assign in_ready = (state_q == DROP) || ((fill <= 5'd8) && !eod_q);
    assign in_fire  = in_valid && in_ready;
    assign sz       = le16(head[63:48]);
    assign need     = (body_rem_q >= 16'd8) ? 5'd8 : body_rem_q[4:0];

    byte_shift_buf u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (buf_clear),
        .push      (in_fire),
        .push_data (in_data),
        .push_n    (in_bytes),
        .pop_n     (pop_n),
        .head      (head),
        .fill      (fill)
    );

    // Parser FSM: one consume step per cycle, header/size/body decisions and counters.
    always_comb begin
        state_d           = state_q;
        eod_d             = eod_q | (in_fire & in_last);
        hdr_half_d        = hdr_half_q;
        hdr_lo_d          = hdr_lo_q;
        body_rem_d        = body_rem_q;
        sop_pend_d        = sop_pend_q;
        out_valid_d       = 1'b0;
        out_sop_d         = 1'b0;
        out_eop_d         = 1'b0;
        out_err_d         = 1'b0;
        out_data_d        = out_data_q;
        out_bytes_d       = out_bytes_q;
        msg_seq_num_d     = msg_seq_num_q;
        sending_time_d    = sending_time_q;
        msg_size_d        = msg_size_q;
        msg_template_id_d = msg_template_id_q;
        pkt_count_d       = pkt_count_q;
        msg_count_d       = msg_count_q;
        err_count_d       = err_count_q;
        pop_n             = 4'd0;
        buf_clear         = 1'b0;
        to_idle           = 1'b0;
        err_inc           = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_fire) state_d = PKT_HDR;
            end
            PKT_HDR: begin
                if (!hdr_half_q) begin
                    if (fill >= 5'd8) begin
                        pop_n      = 4'd8;
                        hdr_lo_d   = head;
                        hdr_half_d = 1'b1;
                    end else if (eod_q) begin
                        err_inc = 1'b1;
                        to_idle = 1'b1;
                    end
                end else begin
                    if (fill >= 5'(PKT_HDR_BYTES - 8)) begin
                        pop_n          = 4'(PKT_HDR_BYTES - 8);
                        msg_seq_num_d  = le32(hdr_lo_q[63:32]);
                        sending_time_d = le64({hdr_lo_q[31:0], head[63:32]});
                        pkt_count_d    = sat_inc(pkt_count_q);
                        hdr_half_d     = 1'b0;
                        state_d        = MSG_SIZE;
                    end else if (eod_q) begin
                        err_inc = 1'b1;
                        to_idle = 1'b1;
                    end
                end
            end
            MSG_SIZE: begin
                if (fill >= 5'(MSG_SIZE_BYTES)) begin
                    pop_n = 4'(MSG_SIZE_BYTES);
                    if (sz < 16'(MIN_MSG_SIZE)) begin
                        err_inc = 1'b1;
                        if (eod_d) begin
                            to_idle = 1'b1;
                        end else begin
                            buf_clear = 1'b1;
                            state_d   = DROP;
                        end
                    end else begin
                        msg_size_d = sz;
                        body_rem_d = sz - 16'(MSG_SIZE_BYTES);
                        sop_pend_d = 1'b1;
                        state_d    = MSG_BODY;
                    end
                end else if (eod_q) begin
                    // An empty buffer here is the clean end of a datagram.
                    if (fill != 5'd0) err_inc = 1'b1;
                    to_idle = 1'b1;
                end
            end
            MSG_BODY: begin
                if (fill >= need) begin
                    pop_n       = need[3:0];
                    out_valid_d = 1'b1;
                    out_data_d  = keep_bytes(head, need[3:0]);
                    out_bytes_d = need[3:0];
                    out_sop_d   = sop_pend_q;
                    if (sop_pend_q) msg_template_id_d = le16(head[47:32]);
                    sop_pend_d  = 1'b0;
                    body_rem_d  = body_rem_q - {11'd0, need};
                    if (body_rem_q == {11'd0, need}) begin
                        out_eop_d   = 1'b1;
                        msg_count_d = sat_inc(msg_count_q);
                        state_d     = MSG_SIZE;
                    end
                end else if (eod_q) begin
                    // Datagram ended inside the body: flush what is left as an errored tail.
                    if (fill != 5'd0) begin
                        out_valid_d = 1'b1;
                        out_data_d  = keep_bytes(head, fill[3:0]);
                        out_bytes_d = fill[3:0];
                        out_sop_d   = sop_pend_q;
                        out_eop_d   = 1'b1;
                        out_err_d   = 1'b1;
                        if (sop_pend_q && fill >= 5'(SBE_HDR_BYTES))
                            msg_template_id_d = le16(head[47:32]);
                    end
                    err_inc = 1'b1;
                    to_idle = 1'b1;
                end
            end
            DROP: begin
                buf_clear = 1'b1;
                if (in_fire && in_last) to_idle = 1'b1;
            end
            default: to_idle = 1'b1;
        endcase

        if (err_inc) err_count_d = sat_inc(err_count_q);
        if (to_idle) begin
            state_d    = IDLE;
            buf_clear  = 1'b1;
            eod_d      = 1'b0;
            hdr_half_d = 1'b0;
            sop_pend_d = 1'b0;
        end
    end

    // Control, output and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            eod_q             <= 1'b0;
            hdr_half_q        <= 1'b0;
            body_rem_q        <= 16'd0;
            sop_pend_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            out_sop_q         <= 1'b0;
            out_eop_q         <= 1'b0;
            out_err_q         <= 1'b0;
            out_data_q        <= 64'd0;
            out_bytes_q       <= 4'd0;
            msg_seq_num_q     <= 32'd0;
            sending_time_q    <= 64'd0;
            msg_size_q        <= 16'd0;
            msg_template_id_q <= 16'd0;
            pkt_count_q       <= '0;
            msg_count_q       <= '0;
            err_count_q       <= '0;
        end else begin
            state_q           <= state_d;
            eod_q             <= eod_d;
            hdr_half_q        <= hdr_half_d;
            body_rem_q        <= body_rem_d;
            sop_pend_q        <= sop_pend_d;
            out_valid_q       <= out_valid_d;
            out_sop_q         <= out_sop_d;
            out_eop_q         <= out_eop_d;
            out_err_q         <= out_err_d;
            out_data_q        <= out_data_d;
            out_bytes_q       <= out_bytes_d;
            msg_seq_num_q     <= msg_seq_num_d;
            sending_time_q    <= sending_time_d;
            msg_size_q        <= msg_size_d;
            msg_template_id_q <= msg_template_id_d;
            pkt_count_q       <= pkt_count_d;
            msg_count_q       <= msg_count_d;
            err_count_q       <= err_count_d;
        end
    end

    // Low half of the packet header, held between the two header steps.
    always_ff @(posedge clk) begin
        hdr_lo_q <= hdr_lo_d;
    end

    assign out_valid       = out_valid_q;
    assign out_sop         = out_sop_q;
    assign out_eop         = out_eop_q;
    assign out_err         = out_err_q;
    assign out_data        = out_data_q;
    assign out_bytes       = out_bytes_q;
    assign msg_seq_num     = msg_seq_num_q;
    assign sending_time    = sending_time_q;
    assign msg_size        = msg_size_q;
    assign msg_template_id = msg_template_id_q;
    assign pkt_count       = pkt_count_q;
    assign msg_count       = msg_count_q;
    assign err_count       = err_count_q;

endmodule
